// File: rtl/sm_accum.sv
// Block accumulator: sums each group of COUNT sign-magnitude samples with
// saturating arithmetic and holds the block sum until the consumer takes it.
module sm_accum #(
  parameter int WIDTH = 32,
  parameter int COUNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat
);

  localparam int MW = WIDTH - 1;
  localparam logic [15:0] LAST = 16'(COUNT - 1);

  typedef enum logic {ACC, OUT} state_t;

  state_t            state_q, state_d;
  logic              acc_sign_q, acc_sign_d;
  logic [MW-1:0]     acc_mag_q, acc_mag_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;
  logic [WIDTH:0]    add_res;

  // Returns {saturated, sign, magnitude}; -0 on either side counts as +0 and
  // a zero result is always emitted with a positive sign.
  function automatic logic [WIDTH:0] sm_add(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic          sa, sb, sr, sat;
    logic [MW-1:0] ma, mb, mr;
    logic [MW:0]   sum;
    ma  = a[MW-1:0];
    mb  = b[MW-1:0];
    sa  = a[WIDTH-1] & (ma != '0);
    sb  = b[WIDTH-1] & (mb != '0);
    sat = 1'b0;
    sum = '0;
    if (sa == sb) begin
      sum = {1'b0, ma} + {1'b0, mb};
      sr  = sa;
      if (sum[MW]) begin
        mr  = '1;
        sat = 1'b1;
      end else begin
        mr = sum[MW-1:0];
      end
    end else if (ma > mb) begin
      mr = ma - mb;
      sr = sa;
    end else begin
      mr = mb - ma;
      sr = sb;
    end
    if (mr == '0) sr = 1'b0;
    return {sat, sr, mr};
  endfunction

  always_comb begin
    state_d    = state_q;
    acc_sign_d = acc_sign_q;
    acc_mag_d  = acc_mag_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    add_res    = sm_add({acc_sign_q, acc_mag_q}, in_data);
    case (state_q)
      ACC: begin
        if (in_valid) begin
          if (cnt_q == LAST) begin
            out_data_d = add_res[WIDTH-1:0];
            out_sat_d  = sat_q | add_res[WIDTH];
            state_d    = OUT;
          end else begin
            acc_sign_d = add_res[WIDTH-1];
            acc_mag_d  = add_res[MW-1:0];
            sat_d      = sat_q | add_res[WIDTH];
            cnt_d      = cnt_q + 16'd1;
          end
        end
      end
      OUT: begin
        // out_data/out_sat keep the block result until the next block ends.
        if (out_ready) begin
          state_d    = ACC;
          acc_sign_d = 1'b0;
          acc_mag_d  = '0;
          cnt_d      = '0;
          sat_d      = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      acc_sign_q <= 1'b0;
      acc_mag_q  <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_sign_q <= acc_sign_d;
      acc_mag_q  <= acc_mag_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == ACC) && !rst;
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
